// File: rtl/cpuy_pkg.sv
// rtl/cpuy_pkg.sv - shared widths, opcode constants and fetch FSM states
package cpuy_pkg;

  localparam int ADDR_W           = 8;
  localparam int DATA_W           = 8;
  localparam int OPERAND_FLAG_BIT = 7;

  localparam logic [DATA_W-1:0] OPC_NOP  = 8'h00;
  localparam logic [ADDR_W-1:0] PC_RESET = 8'h00;

  typedef enum logic [1:0] {
    FETCH_OP,
    FETCH_ARG,
    ISSUE,
    RESOLVE
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch FSM: opcode/operand reads, issue handshake, jump resolve
module fetch_unit
  import cpuy_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] opcode,
  output logic [DATA_W-1:0] operand,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              jump_taken,
  input  logic [ADDR_W-1:0] jump_target,
  output logic [ADDR_W-1:0] pc
);

  fetch_state_e      state_q;
  logic              mem_req_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] opcode_q;
  logic [DATA_W-1:0] operand_q;
  logic              instr_valid_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_inc_d;
  logic              rd_done;

  // Natural 8-bit wrap gives modulo-256 pc arithmetic.
  assign pc_inc_d = pc_q + ADDR_W'(1);
  assign rd_done  = mem_req_q & mem_ack;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= FETCH_OP;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= PC_RESET;
      opcode_q      <= OPC_NOP;
      operand_q     <= '0;
      instr_valid_q <= 1'b0;
      pc_q          <= PC_RESET;
    end else begin
      case (state_q)
        FETCH_OP: begin
          // Only entered with mem_req low straight out of reset.
          if (!mem_req_q) begin
            mem_req_q  <= 1'b1;
            mem_addr_q <= pc_q;
          end else if (rd_done) begin
            opcode_q <= mem_rdata;
            pc_q     <= pc_inc_d;
            if (mem_rdata[OPERAND_FLAG_BIT]) begin
              mem_addr_q <= pc_inc_d;
              state_q    <= FETCH_ARG;
            end else begin
              operand_q     <= '0;
              mem_req_q     <= 1'b0;
              instr_valid_q <= 1'b1;
              state_q       <= ISSUE;
            end
          end
        end
        FETCH_ARG: begin
          if (rd_done) begin
            operand_q     <= mem_rdata;
            pc_q          <= pc_inc_d;
            mem_req_q     <= 1'b0;
            instr_valid_q <= 1'b1;
            state_q       <= ISSUE;
          end
        end
        ISSUE: begin
          if (instr_ready) begin
            instr_valid_q <= 1'b0;
            state_q       <= RESOLVE;
          end
        end
        RESOLVE: begin
          // Launch the next opcode read directly at the resolved pc.
          mem_req_q <= 1'b1;
          state_q   <= FETCH_OP;
          if (jump_taken) begin
            pc_q       <= jump_target;
            mem_addr_q <= jump_target;
          end else begin
            mem_addr_q <= pc_q;
          end
        end
        default: state_q <= FETCH_OP;
      endcase
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign opcode      = opcode_q;
  assign operand     = operand_q;
  assign instr_valid = instr_valid_q;
  assign pc          = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed table and sequence bench for fetch_unit
module tb_fetch_unit;
  import cpuy_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic       mem_ack = 1'b0;
  logic [7:0] mem_rdata = 8'hEE;
  logic [7:0] opcode;
  logic [7:0] operand;
  logic       instr_valid;
  logic       instr_ready = 1'b0;
  logic       jump_taken = 1'b0;
  logic [7:0] jump_target = 8'h00;
  logic [7:0] pc;

  logic [7:0] mem [256];
  int         ack_delay = 0;
  int         wait_cnt = 0;
  bit         force_ack = 1'b0;
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .opcode     (opcode),
    .operand    (operand),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .jump_taken (jump_taken),
    .jump_target(jump_target),
    .pc         (pc)
  );

  // Memory model: acks after ack_delay waiting cycles; force_ack injects a bogus ack.
  always @(negedge clk) begin
    if (force_ack) begin
      mem_ack   = 1'b1;
      mem_rdata = 8'hC3;
    end else if (mem_req && wait_cnt >= ack_delay) begin
      mem_ack   = 1'b1;
      mem_rdata = mem[mem_addr];
      wait_cnt  = 0;
    end else begin
      mem_ack   = 1'b0;
      mem_rdata = 8'hEE;
      wait_cnt  = mem_req ? wait_cnt + 1 : 0;
    end
  end

  typedef struct {
    logic [7:0] start;
    logic [7:0] b0;
    logic [7:0] b1;
    int         delay;
    logic [7:0] exp_op;
    logic [7:0] exp_opnd;
    logic [7:0] exp_pc;
    int         exp_lat;
  } vec_t;

  vec_t vecs [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic clear_mem();
    for (int a = 0; a < 256; a++) mem[a] = 8'h00;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    jump_taken = 1'b0;
    force_ack  = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!instr_valid && lat < 64) begin
      tick();
      lat++;
    end
    check("valid_timeout", instr_valid, 1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_mem_req"}, mem_req, 0);
    check({tag, "_mem_addr"}, mem_addr, 8'h00);
    check({tag, "_opcode"}, opcode, 8'h00);
    check({tag, "_operand"}, operand, 8'h00);
    check({tag, "_valid"}, instr_valid, 0);
    check({tag, "_pc"}, pc, 8'h00);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int         lat;
    bit         found;
    logic [7:0] idx;

    vecs[0] = '{8'h00, 8'h02, 8'h00, 0, 8'h02, 8'h00, 8'h01, 1};
    vecs[1] = '{8'h00, 8'h84, 8'h5A, 2, 8'h84, 8'h5A, 8'h02, 6};
    vecs[2] = '{8'hFF, 8'h90, 8'h11, 0, 8'h90, 8'h11, 8'h01, 2};
    vecs[3] = '{8'h40, 8'hA2, 8'h40, 1, 8'hA2, 8'h40, 8'h42, 4};
    vecs[4] = '{8'hFE, 8'h7F, 8'h00, 3, 8'h7F, 8'h00, 8'hFF, 4};
    vecs[5] = '{8'hFF, 8'h05, 8'h00, 0, 8'h05, 8'h00, 8'h00, 1};

    // Reset values and single-byte zero-wait latency.
    clear_mem();
    mem[0] = 8'h02;
    ack_delay = 0;
    instr_ready = 1'b1;
    rst_n = 1'b0;
    tick();
    tick();
    check_reset_vals("rst");
    rst_n = 1'b1;
    tick();
    check("first_req", mem_req, 1);
    check("first_addr", mem_addr, 8'h00);
    check("first_valid", instr_valid, 0);
    tick();
    check("sb_valid", instr_valid, 1);
    check("sb_opcode", opcode, 8'h02);
    check("sb_operand", operand, 8'h00);
    check("sb_pc", pc, 8'h01);
    check("sb_issue_req", mem_req, 0);
    tick();
    check("sb_resolve_valid", instr_valid, 0);
    check("sb_resolve_req", mem_req, 0);
    tick();
    check("sb_next_req", mem_req, 1);
    check("sb_next_addr", mem_addr, 8'h01);

    // Two-byte fetch with 2-cycle ack delay: addresses held until ack.
    clear_mem();
    mem[0] = 8'h84;
    mem[1] = 8'h5A;
    ack_delay = 2;
    do_reset();
    tick();
    for (int k = 0; k < 6; k++) begin
      check("slow_req", mem_req, 1);
      check("slow_addr", mem_addr, (k < 3) ? 8'h00 : 8'h01);
      check("slow_valid", instr_valid, 0);
      tick();
    end
    check("slow_issue_valid", instr_valid, 1);
    check("slow_opcode", opcode, 8'h84);
    check("slow_operand", operand, 8'h5A);
    check("slow_pc", pc, 8'h02);

    // Jump taken in RESOLVE.
    clear_mem();
    mem[0] = 8'hA2;
    mem[1] = 8'h40;
    ack_delay = 0;
    instr_ready = 1'b1;
    do_reset();
    wait_valid(lat);
    check("jmp_opcode", opcode, 8'hA2);
    check("jmp_operand", operand, 8'h40);
    tick();
    jump_taken  = 1'b1;
    jump_target = 8'h40;
    tick();
    jump_taken = 1'b0;
    check("jmp_req", mem_req, 1);
    check("jmp_addr", mem_addr, 8'h40);
    check("jmp_pc", pc, 8'h40);

    // Jump pulse coinciding with the ISSUE handshake only is ignored.
    instr_ready = 1'b0;
    do_reset();
    wait_valid(lat);
    jump_taken  = 1'b1;
    jump_target = 8'h40;
    instr_ready = 1'b1;
    tick();
    jump_taken = 1'b0;
    tick();
    check("nojmp_addr", mem_addr, 8'h02);
    check("nojmp_pc", pc, 8'h02);

    // Consumer stall for 5 cycles with spurious acks.
    clear_mem();
    mem[0] = 8'h84;
    mem[1] = 8'h5A;
    ack_delay = 0;
    instr_ready = 1'b0;
    do_reset();
    wait_valid(lat);
    force_ack = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("stall_valid", instr_valid, 1);
      check("stall_opcode", opcode, 8'h84);
      check("stall_operand", operand, 8'h5A);
      check("stall_req", mem_req, 0);
      check("stall_pc", pc, 8'h02);
    end
    force_ack = 1'b0;
    instr_ready = 1'b1;
    tick();
    check("stall_resolve_valid", instr_valid, 0);
    tick();
    check("stall_next_addr", mem_addr, 8'h02);

    // Reset during FETCH_ARG with a stale ack arriving across reset.
    ack_delay = 3;
    do_reset();
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      tick();
      if (mem_req && mem_addr == 8'h01) found = 1'b1;
    end
    check("reach_fetch_arg", found, 1);
    rst_n = 1'b0;
    force_ack = 1'b1;
    tick();
    check_reset_vals("midrst");
    tick();
    check("midrst2_opcode", opcode, 8'h00);
    rst_n = 1'b1;
    tick();
    check("stale_opcode", opcode, 8'h00);
    check("stale_operand", operand, 8'h00);
    check("stale_req", mem_req, 1);
    check("stale_addr", mem_addr, 8'h00);
    check("stale_pc", pc, 8'h00);
    force_ack = 1'b0;
    wait_valid(lat);
    check("after_rst_opcode", opcode, 8'h84);

    // Table: preamble instruction at 0, jump to start, then fetch the vector.
    instr_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      clear_mem();
      idx = vecs[i].start;
      mem[idx] = vecs[i].b0;
      idx = idx + 8'd1;
      mem[idx] = vecs[i].b1;
      ack_delay = 0;
      do_reset();
      wait_valid(lat);
      ack_delay   = vecs[i].delay;
      jump_taken  = 1'b1;
      jump_target = vecs[i].start;
      tick();
      tick();
      jump_taken = 1'b0;
      check("vec_req", mem_req, 1);
      check("vec_addr", mem_addr, vecs[i].start);
      wait_valid(lat);
      check("vec_latency", lat, vecs[i].exp_lat);
      check("vec_opcode", opcode, vecs[i].exp_op);
      check("vec_operand", operand, vecs[i].exp_opnd);
      check("vec_pc", pc, vecs[i].exp_pc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
